// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop sync + counter debounce with edge pulses; define DEBOUNCE_LONG_PRESS_EN for o_Hold
module debounce_bank #(
  parameter int   NUM_CH         = 4,
  parameter int   DEBOUNCE_LIMIT = 250000,
  parameter logic INIT_LEVEL     = 1'b0,
  parameter int   HOLD_LIMIT     = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Hold
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
  if (NUM_CH < 1 || NUM_CH > 32 || DEBOUNCE_LIMIT < 1 || HOLD_LIMIT < 1) begin : g_bad_params
    $error("debounce_bank: parameter out of range");
  end
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic          sync1, sync2, level, rise, fall;
    logic [CW-1:0] cnt;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        sync1 <= INIT_LEVEL;
        sync2 <= INIT_LEVEL;
        level <= INIT_LEVEL;
        cnt   <= '0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        sync1 <= i_Switch[i];
        sync2 <= sync1;
        rise  <= 1'b0;
        fall  <= 1'b0;
        if (sync2 == level) cnt <= '0;
        else if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else cnt <= cnt + CW'(1);
      end
    end
    assign o_Level[i] = level;
    assign o_Rise[i]  = rise;
    assign o_Fall[i]  = fall;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
    logic [HW-1:0] hcnt;
    logic          hold;
    // hcnt saturates at HOLD_MAX so a single press yields a single pulse
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        hcnt <= '0;
        hold <= 1'b0;
      end else begin
        hold <= level && (hcnt == HOLD_MAX - HW'(1));
        hcnt <= !level ? '0 : (hcnt == HOLD_MAX ? hcnt : hcnt + HW'(1));
      end
    end
    assign o_Hold[i] = hold;
`else
    assign o_Hold[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed + random stimulus against a sample-window reference model
module tb_debounce_bank;
  localparam int N = 2, LIM = 4, HOLD = 10;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [1:0] HOLD_EXP = 2'b01;
  localparam bit HOLD_ON = 1'b1;
`else
  localparam logic [1:0] HOLD_EXP = 2'b00;
  localparam bit HOLD_ON = 1'b0;
`endif
  logic i_Clk = 1'b0, i_Rst_L = 1'b1;
  logic [N-1:0] i_Switch = '0;
  logic [N-1:0] o_Level, o_Rise, o_Fall, o_Hold;
  int checks = 0, failures = 0;
  int rises0 = 0, holds0 = 0;
  logic [N-1:0] p1, p2, m_level, m_rise, m_fall, m_hold;
  logic win [N][LIM];
  int n = 0;
  int hs [N];
  logic [N-1:0] sw;

  debounce_bank #(.NUM_CH(N), .DEBOUNCE_LIMIT(LIM), .INIT_LEVEL(1'b0), .HOLD_LIMIT(HOLD)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Level(o_Level), .o_Rise(o_Rise), .o_Fall(o_Fall), .o_Hold(o_Hold));

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    p1 = '0; p2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_hold = '0;
    for (int c = 0; c < N; c++) begin
      hs[c] = 0;
      for (int k = 0; k < LIM; k++) win[c][k] = 1'b0;
    end
  endtask

  // level flips when the last LIM synchronised samples all disagree with it
  task automatic model_edge(input logic [N-1:0] pin);
    logic [N-1:0] s2;
    bit all_diff;
    s2 = p2; p2 = p1; p1 = pin;
    for (int c = 0; c < N; c++) begin
      for (int k = LIM - 1; k > 0; k--) win[c][k] = win[c][k-1];
      win[c][0] = s2[c];
      all_diff = 1'b1;
      for (int k = 0; k < LIM; k++) if (win[c][k] == m_level[c]) all_diff = 1'b0;
      m_hold[c] = HOLD_ON && m_level[c] && (n - hs[c] == HOLD);
      m_rise[c] = all_diff && s2[c];
      m_fall[c] = all_diff && !s2[c];
      if (all_diff) begin
        m_level[c] = s2[c];
        if (s2[c]) hs[c] = n;
      end
    end
    n++;
  endtask

  task automatic step(input logic [N-1:0] pin);
    i_Switch = pin;
    @(posedge i_Clk);
    model_edge(pin);
    #1;
    chk("level", o_Level, m_level);
    chk("rise", o_Rise, m_rise);
    chk("fall", o_Fall, m_fall);
    chk("hold", o_Hold, m_hold);
    chk("rise_fall_excl", o_Rise & o_Fall, 0);
    rises0 += int'(o_Rise[0]);
    holds0 += int'(o_Hold[0]);
  endtask

  task automatic do_reset(input logic [N-1:0] pin);
    i_Switch = pin;
    i_Rst_L = 1'b0;
    #1;
    model_reset();
    chk("rst_level", o_Level, 0);
    chk("rst_rise", o_Rise, 0);
    chk("rst_fall", o_Fall, 0);
    chk("rst_hold", o_Hold, 0);
    repeat (2) @(posedge i_Clk);
    #2;
    i_Rst_L = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(2'b00);
    repeat (3) step(2'b00);
    // clean press on channel 0, then hold for long press
    repeat (5) step(2'b01);
    chk("press_pre", o_Level, 2'b00);
    step(2'b01);
    chk("press_level", o_Level, 2'b01);
    chk("press_rise", o_Rise, 2'b01);
    step(2'b01);
    chk("press_rise_once", o_Rise, 2'b00);
    repeat (8) step(2'b01);
    chk("hold_pre", o_Hold, 2'b00);
    step(2'b01);
    chk("hold_fire", o_Hold, HOLD_EXP);
    step(2'b01);
    chk("hold_once", o_Hold, 2'b00);
    // release
    repeat (5) step(2'b00);
    chk("release_pre", o_Level, 2'b01);
    step(2'b00);
    chk("release_level", o_Level, 2'b00);
    chk("release_fall", o_Fall, 2'b01);
    step(2'b00);
    // bounce: 3 high, 1 low, then steady high
    rises0 = 0; holds0 = 0;
    repeat (3) step(2'b01);
    step(2'b00);
    repeat (5) step(2'b01);
    chk("bounce_pre_level", o_Level, 2'b00);
    chk("bounce_pre_rises", rises0, 0);
    step(2'b01);
    chk("bounce_level", o_Level, 2'b01);
    chk("bounce_rise", o_Rise, 2'b01);
    step(2'b01);
    chk("bounce_rises", rises0, 1);
    repeat (6) step(2'b00);
    // short press: 6 cycles at level 1, no hold
    repeat (6) step(2'b01);
    repeat (8) step(2'b00);
    chk("short_level", o_Level, 2'b00);
    chk("short_no_hold", holds0, 0);
    // simultaneous press on both channels
    repeat (5) step(2'b11);
    chk("simul_pre", o_Level, 2'b00);
    step(2'b11);
    chk("simul_level", o_Level, 2'b11);
    chk("simul_rise", o_Rise, 2'b11);
    repeat (7) step(2'b00);
    // reset after two counting edges
    repeat (4) step(2'b01);
    do_reset(2'b01);
    rises0 = 0;
    repeat (5) step(2'b01);
    chk("rstmid_pre", o_Level, 2'b00);
    chk("rstmid_no_pulse", rises0, 0);
    step(2'b01);
    chk("rstmid_level", o_Level, 2'b01);
    chk("rstmid_rise", o_Rise, 2'b01);
    // random toggling with occasional long runs
    sw = 2'b01;
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 9) == 0) sw[c] = ~sw[c];
      if (t == 200) do_reset(sw);
      step(sw);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
